// File: rtl/da_fir_pipe_if.sv
// rtl/da_fir_pipe_if.sv - Sample-in / result-out stream bundle for the DA FIR filter
interface da_fir_pipe_if #(
   parameter int OPSIZE = 12,
   parameter int OUT_W  = 27
);
   logic                     i_valid;
   logic                     o_ready;
   logic signed [OPSIZE-1:0] i_x;
   logic                     o_valid;
   logic                     i_ready;
   logic signed [OUT_W-1:0]  o_y;

   // Filter side: consumes samples, produces results
   modport slave (
      input  i_valid, i_x, i_ready,
      output o_ready, o_valid, o_y
   );

   // Source/sink side: drives samples, accepts results
   modport master (
      output i_valid, i_x, i_ready,
      input  o_ready, o_valid, o_y
   );
endinterface

// File: rtl/da_fir_pipe.sv
// rtl/da_fir_pipe.sv - Bit-serial distributed-arithmetic FIR, BAAT bit-planes per clock
module da_fir_pipe #(
   parameter int OPSIZE    = 12,
   parameter int ORDER     = 6,
   parameter int BAAT      = 3,
   parameter int PARTITION = 2,
   parameter int COEF_W    = 12,
   parameter logic [ORDER*COEF_W-1:0] COEFS =
      {12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1}
) (
   input  logic        clk,
   input  logic        rst_n,
   da_fir_pipe_if.slave bus
);

   localparam int OUT_W     = OPSIZE + COEF_W + $clog2(ORDER);
   localparam int NCYC      = OPSIZE / BAAT;
   localparam int K         = ORDER / PARTITION;
   localparam int LUT_DEPTH = 1 << K;
   localparam int LUT_BITS  = PARTITION * LUT_DEPTH * OUT_W;
   localparam int CNT_W     = (NCYC > 1) ? $clog2(NCYC) : 1;
   localparam int IDX_W     = (OPSIZE > 1) ? $clog2(OPSIZE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

   // Entry a of sub-table p is the sum of the coefficients whose tap bit is set in a,
   // sign-extended to the full output width. All tables are packed into one vector.
   function automatic logic [LUT_BITS-1:0] build_lut();
      logic [LUT_BITS-1:0]     flat;
      logic signed [OUT_W-1:0] entry;
      flat = '0;
      for (int p = 0; p < PARTITION; p++) begin
         for (int a = 0; a < LUT_DEPTH; a++) begin
            entry = '0;
            for (int j = 0; j < K; j++) begin
               if (a[j]) begin
                  entry = entry + OUT_W'(signed'(COEFS[(p*K+j)*COEF_W +: COEF_W]));
               end
            end
            flat[(p*LUT_DEPTH+a)*OUT_W +: OUT_W] = entry;
         end
      end
      return flat;
   endfunction

   localparam logic [LUT_BITS-1:0] LUT_FLAT = build_lut();

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      OUT
   } state_t;

   state_t                   state_q;
   state_t                   state_d;
   logic signed [OPSIZE-1:0] taps [ORDER];
   logic signed [OUT_W-1:0]  acc;
   logic signed [OUT_W-1:0]  y_q;
   logic [CNT_W-1:0]         cnt;

   logic                     o_ready_c;
   logic                     accept;
   logic signed [OUT_W-1:0]  plane_total;
   logic signed [OUT_W-1:0]  psum;
   logic [K-1:0]             addr;
   logic [IDX_W-1:0]         bidx;
   int                       m;

   // Control: IDLE waits for a sample, CALC walks the bit-planes, OUT holds the result
   always_comb begin
      state_d   = state_q;
      o_ready_c = 1'b0;
      case (state_q)
         IDLE: begin
            o_ready_c = 1'b1;
            if (bus.i_valid) begin
               state_d = CALC;
            end
         end
         CALC: begin
            if (cnt == CNT_LAST) begin
               state_d = OUT;
            end
         end
         OUT: begin
            // A new sample may enter on the same edge that the result leaves
            o_ready_c = bus.i_ready;
            if (bus.i_ready) begin
               state_d = bus.i_valid ? CALC : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept      = bus.i_valid && o_ready_c;
   assign bus.o_ready = o_ready_c;
   assign bus.o_valid = (state_q == OUT);
   assign bus.o_y     = y_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Weighted sum of this clock's BAAT bit-planes; the MSB plane carries negative weight
   always_comb begin
      plane_total = '0;
      psum        = '0;
      addr        = '0;
      m           = 0;
      bidx        = '0;
      for (int b = 0; b < BAAT; b++) begin
         m    = int'(cnt) * BAAT + b;
         bidx = IDX_W'(m);
         psum = '0;
         for (int p = 0; p < PARTITION; p++) begin
            for (int j = 0; j < K; j++) begin
               addr[j] = taps[p*K+j][bidx];
            end
            psum = psum + LUT_FLAT[(p*LUT_DEPTH + int'(addr))*OUT_W +: OUT_W];
         end
         if (m == OPSIZE - 1) begin
            plane_total = plane_total - (psum <<< m);
         end else begin
            plane_total = plane_total + (psum <<< m);
         end
      end
   end

   // Tap line shift on accept, plane accumulation in CALC, result capture on the last plane
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < ORDER; k++) begin
            taps[k] <= '0;
         end
         acc <= '0;
         cnt <= '0;
         y_q <= '0;
      end else if (accept) begin
         taps[0] <= bus.i_x;
         for (int k = 1; k < ORDER; k++) begin
            taps[k] <= taps[k-1];
         end
         acc <= '0;
         cnt <= '0;
      end else if (state_q == CALC) begin
         cnt <= cnt + 1'b1;
         if (cnt == CNT_LAST) begin
            y_q <= acc + plane_total;
         end else begin
            acc <= acc + plane_total;
         end
      end
   end

endmodule

// File: tb/tb_da_fir_pipe.sv
// tb/tb_da_fir_pipe.sv - Self-checking bench for da_fir_pipe against a direct-form FIR model
module tb_da_fir_pipe;
   localparam int OPSIZE = 12;
   localparam int ORDER  = 6;
   localparam int OUT_W  = 27;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   da_fir_pipe_if #(.OPSIZE(OPSIZE), .OUT_W(OUT_W)) bus  ();
   da_fir_pipe_if #(.OPSIZE(OPSIZE), .OUT_W(OUT_W)) bus2 ();

   da_fir_pipe dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   da_fir_pipe #(.BAAT(1), .PARTITION(3)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2.slave)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int accept_cyc  = 0;
   int hist [ORDER];
   int coef [ORDER] = '{1, 2, 3, 4, 5, 6};

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void model_clear();
      for (int k = 0; k < ORDER; k++) hist[k] = 0;
   endfunction

   // y[n] = sum h[k] * x[n-k]
   function automatic int model_push(input int x);
      int s;
      for (int k = ORDER - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = x;
      s = 0;
      for (int k = 0; k < ORDER; k++) s += coef[k] * hist[k];
      return s;
   endfunction

   task automatic start_sample(input int x, output bit ok);
      int guard;
      guard       = 0;
      bus.i_x     = OPSIZE'(x);
      bus.i_valid = 1'b1;
      while (!bus.o_ready && guard < 64) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!bus.o_ready) begin
         bus.i_valid = 1'b0;
         ok = 1'b0;
      end else begin
         @(posedge clk); #1;
         accept_cyc  = cyc;
         bus.i_valid = 1'b0;
         ok = 1'b1;
      end
   endtask

   task automatic wait_output(output logic signed [OUT_W-1:0] y, output int lat, output bit ok);
      lat = 0;
      while (!bus.o_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      ok = bus.o_valid;
      y  = bus.o_y;
   endtask

   task automatic run_sample(input int x, output logic signed [OUT_W-1:0] y,
                             output int lat, output bit ok);
      bit ok1, ok2;
      start_sample(x, ok1);
      wait_output(y, lat, ok2);
      ok = ok1 && ok2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.i_valid = 1'b0; bus.i_ready = 1'b1; bus.i_x = '0;
      bus2.i_valid = 1'b0; bus2.i_ready = 1'b1; bus2.i_x = '0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (bus.o_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_o_valid got=%b want=0", bus.o_valid);
      end
      vectors++;
      if (bus.o_y !== '0) begin
         miscompares++;
         $display("FAIL reset_o_y got=%0d want=0", bus.o_y);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      vectors++;
      if (bus.o_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_o_ready got=%b want=1", bus.o_ready);
      end
   endtask

   task automatic test_sequence(input string name, input int xs [$]);
      logic signed [OUT_W-1:0] y;
      int lat, exp;
      bit ok;
      foreach (xs[i]) begin
         run_sample(xs[i], y, lat, ok);
         exp = model_push(xs[i]);
         vectors++;
         if (!ok || y !== exp || lat != 4) begin
            miscompares++;
            $display("FAIL %s[%0d] got=%0d lat=%0d ok=%b want=%0d lat=4", name, i, y, lat, ok, exp);
         end
      end
   endtask

   task automatic test_impulse();
      test_sequence("impulse", '{1, 0, 0, 0, 0, 0, 0});
   endtask

   task automatic test_neg_impulse();
      test_sequence("neg_impulse", '{-1, 0, 0, 0, 0, 0, 0});
   endtask

   task automatic test_extremes();
      logic signed [OUT_W-1:0] y;
      int lat;
      bit ok;
      test_sequence("step_pos", '{2047, 2047, 2047, 2047, 2047});
      run_sample(2047, y, lat, ok);
      void'(model_push(2047));
      vectors++;
      if (y !== 42987) begin
         miscompares++;
         $display("FAIL step_pos_final got=%0d want=42987", y);
      end
      test_sequence("step_neg", '{-2048, -2048, -2048, -2048, -2048});
      run_sample(-2048, y, lat, ok);
      void'(model_push(-2048));
      vectors++;
      if (y !== -43008) begin
         miscompares++;
         $display("FAIL step_neg_final got=%0d want=-43008", y);
      end
   endtask

   task automatic test_backpressure();
      logic signed [OUT_W-1:0] y0, y1;
      int lat, exp;
      bit ok;
      @(posedge clk); #1;
      bus.i_ready = 1'b0;
      start_sample(100, ok);
      wait_output(y0, lat, ok);
      exp = model_push(100);
      vectors++;
      if (!ok || y0 !== exp || lat != 4) begin
         miscompares++;
         $display("FAIL bp_first got=%0d lat=%0d want=%0d lat=4", y0, lat, exp);
      end
      bus.i_x = -12'sd77;
      bus.i_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         vectors++;
         if (bus.o_valid !== 1'b1 || bus.o_y !== y0 || bus.o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold[%0d] o_valid=%b o_y=%0d o_ready=%b want 1/%0d/0",
                     c, bus.o_valid, bus.o_y, bus.o_ready, y0);
         end
      end
      bus.i_ready = 1'b1;
      #1;
      vectors++;
      if (bus.o_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_skid_ready got=%b want=1", bus.o_ready);
      end
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      vectors++;
      if (bus.o_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_consumed o_valid got=%b want=0", bus.o_valid);
      end
      wait_output(y1, lat, ok);
      exp = model_push(-77);
      vectors++;
      if (!ok || y1 !== exp || lat != 4) begin
         miscompares++;
         $display("FAIL bp_second got=%0d lat=%0d want=%0d lat=4", y1, lat, exp);
      end
   endtask

   task automatic test_back_to_back();
      logic signed [OUT_W-1:0] y;
      logic [OPSIZE-1:0] r;
      int lat, exp, x, prev;
      bit ok;
      prev = 0;
      for (int i = 0; i < 8; i++) begin
         r = OPSIZE'($urandom);
         x = int'($signed(r));
         run_sample(x, y, lat, ok);
         exp = model_push(x);
         vectors++;
         if (!ok || y !== exp) begin
            miscompares++;
            $display("FAIL b2b_value[%0d] got=%0d want=%0d", i, y, exp);
         end
         if (i > 0) begin
            vectors++;
            if (accept_cyc - prev != 5) begin
               miscompares++;
               $display("FAIL b2b_spacing[%0d] got=%0d want=5", i, accept_cyc - prev);
            end
         end
         prev = accept_cyc;
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      @(posedge clk); #1;
      start_sample(1234, ok);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (bus.o_valid !== 1'b0 || bus.o_y !== '0) begin
         miscompares++;
         $display("FAIL rst_mid got o_valid=%b o_y=%0d want 0/0", bus.o_valid, bus.o_y);
      end
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         vectors++;
         if (bus.o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_no_output[%0d] o_valid got=%b want=0", c, bus.o_valid);
         end
      end
      test_sequence("impulse_after_reset", '{1, 0, 0, 0, 0, 0, 0});
   endtask

   task automatic test_random();
      logic signed [OUT_W-1:0] y;
      logic [OPSIZE-1:0] r;
      int lat, exp, x, gap;
      bit ok;
      for (int i = 0; i < 20; i++) begin
         r = OPSIZE'($urandom);
         x = int'($signed(r));
         gap = $urandom_range(0, 3);
         repeat (gap) begin
            @(posedge clk); #1;
         end
         run_sample(x, y, lat, ok);
         exp = model_push(x);
         vectors++;
         if (!ok || y !== exp || lat != 4) begin
            miscompares++;
            $display("FAIL random[%0d] x=%0d got=%0d lat=%0d want=%0d lat=4", i, x, y, lat, exp);
         end
      end
   endtask

   task automatic test_reparam();
      logic signed [OUT_W-1:0] y;
      int lat, guard, exp;
      for (int i = 0; i < 7; i++) begin
         bus2.i_x     = (i == 0) ? 12'sd1 : 12'sd0;
         bus2.i_valid = 1'b1;
         guard = 0;
         while (!bus2.o_ready && guard < 64) begin
            @(posedge clk); #1;
            guard++;
         end
         @(posedge clk); #1;
         bus2.i_valid = 1'b0;
         lat = 0;
         while (!bus2.o_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
         end
         y   = bus2.o_y;
         exp = (i < 6) ? i + 1 : 0;
         vectors++;
         if (y !== exp || lat != 12) begin
            miscompares++;
            $display("FAIL reparam[%0d] got=%0d lat=%0d want=%0d lat=12", i, y, lat, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_neg_impulse();
      test_extremes();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_reparam();
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired vectors=%0d", vectors);
      $fatal(1, "watchdog");
   end
endmodule
